// File: rtl/ysyx_22040895_trap_pkg.sv
// Shared definitions for the machine-mode trap/CSR sequencer: op codes,
// CSR addresses, mstatus field positions and the controller state encoding.
package ysyx_22040895_trap_pkg;

    localparam logic [2:0] OP_ECALL = 3'b001;
    localparam logic [2:0] OP_MRET  = 3'b010;
    localparam logic [2:0] OP_CSRRS = 3'b011;
    localparam logic [2:0] OP_CSRRW = 3'b100;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_HI = 12;
    localparam int MSTATUS_MPP_LO = 11;

    localparam logic [63:0] ECALL_CAUSE = 64'd11;

    typedef enum logic [3:0] {
        IDLE,
        EC_RTVEC,
        EC_WEPC,
        EC_WCAUSE,
        EC_RSTAT,
        EC_WSTAT,
        MR_REPC,
        MR_RSTAT,
        MR_WSTAT,
        CS_READ,
        CS_WRITE,
        DONE
    } trap_state_e;

endpackage

// File: rtl/ysyx_22040895_trap_ctrl_mstatus_upd.sv
// Combinational mstatus rewrite for trap entry (ecall) and trap return (mret).
module ysyx_22040895_mstatus_upd
    import ysyx_22040895_trap_pkg::*;
(
    input  logic [63:0] i_mstatus,
    output logic [63:0] o_ecall_mstatus,
    output logic [63:0] o_mret_mstatus
);

    always_comb begin
        o_ecall_mstatus                                = i_mstatus;
        o_ecall_mstatus[MSTATUS_MPIE]                  = i_mstatus[MSTATUS_MIE];
        o_ecall_mstatus[MSTATUS_MIE]                   = 1'b0;
        o_ecall_mstatus[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;

        o_mret_mstatus                                 = i_mstatus;
        o_mret_mstatus[MSTATUS_MIE]                    = i_mstatus[MSTATUS_MPIE];
        o_mret_mstatus[MSTATUS_MPIE]                   = 1'b1;
        o_mret_mstatus[MSTATUS_MPP_HI:MSTATUS_MPP_LO]  = 2'b00;
    end

endmodule

// File: rtl/ysyx_22040895_trap_ctrl.sv
// Trap/CSR sequencer: walks ecall, mret and csrrs/csrrw through a single
// CSR read/write port, one access per cycle, then pulses a response.
module ysyx_22040895_trap_ctrl
    import ysyx_22040895_trap_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [11:0] req_csr_addr,
    input  logic [63:0] req_pc,
    input  logic [63:0] req_rs1,
    output logic [11:0] csr_raddr,
    input  logic [63:0] csr_rdata,
    output logic        csr_we,
    output logic [11:0] csr_waddr,
    output logic [63:0] csr_wdata,
    output logic        resp_valid,
    output logic [63:0] resp_result,
    output logic        redirect_valid,
    output logic [63:0] redirect_pc,
    output logic        busy
);

    trap_state_e r_state;
    trap_state_e w_state_nxt;

    logic [2:0]  r_op;
    logic [11:0] r_csr_addr;
    logic [63:0] r_pc;
    logic [63:0] r_rs1;
    logic [63:0] r_mtvec;
    logic [63:0] r_mepc;
    logic [63:0] r_old;
    logic [63:0] w_ecall_mstatus;
    logic [63:0] w_mret_mstatus;

    // r_old holds whichever CSR value was read last: mstatus on the trap
    // paths, the addressed CSR on the csrrs/csrrw path.
    ysyx_22040895_mstatus_upd u_mstatus_upd (
        .i_mstatus       (r_old),
        .o_ecall_mstatus (w_ecall_mstatus),
        .o_mret_mstatus  (w_mret_mstatus)
    );

    assign busy      = (r_state != IDLE);
    assign req_ready = !busy;

    always_comb begin
        w_state_nxt    = r_state;
        csr_raddr      = '0;
        csr_we         = 1'b0;
        csr_waddr      = '0;
        csr_wdata      = '0;
        resp_valid     = 1'b0;
        resp_result    = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    case (req_op)
                        OP_ECALL:           w_state_nxt = EC_RTVEC;
                        OP_MRET:            w_state_nxt = MR_REPC;
                        OP_CSRRS, OP_CSRRW: w_state_nxt = CS_READ;
                        default:            w_state_nxt = DONE;
                    endcase
                end
            end
            EC_RTVEC: begin
                csr_raddr   = CSR_MTVEC;
                w_state_nxt = EC_WEPC;
            end
            EC_WEPC: begin
                csr_we      = 1'b1;
                csr_waddr   = CSR_MEPC;
                csr_wdata   = r_pc;
                w_state_nxt = EC_WCAUSE;
            end
            EC_WCAUSE: begin
                csr_we      = 1'b1;
                csr_waddr   = CSR_MCAUSE;
                csr_wdata   = ECALL_CAUSE;
                w_state_nxt = EC_RSTAT;
            end
            EC_RSTAT: begin
                csr_raddr   = CSR_MSTATUS;
                w_state_nxt = EC_WSTAT;
            end
            EC_WSTAT: begin
                csr_we      = 1'b1;
                csr_waddr   = CSR_MSTATUS;
                csr_wdata   = w_ecall_mstatus;
                w_state_nxt = DONE;
            end
            MR_REPC: begin
                csr_raddr   = CSR_MEPC;
                w_state_nxt = MR_RSTAT;
            end
            MR_RSTAT: begin
                csr_raddr   = CSR_MSTATUS;
                w_state_nxt = MR_WSTAT;
            end
            MR_WSTAT: begin
                csr_we      = 1'b1;
                csr_waddr   = CSR_MSTATUS;
                csr_wdata   = w_mret_mstatus;
                w_state_nxt = DONE;
            end
            CS_READ: begin
                csr_raddr   = r_csr_addr;
                // csrrs with a zero mask has no architectural side effect
                w_state_nxt = (r_op == OP_CSRRS && r_rs1 == '0) ? DONE : CS_WRITE;
            end
            CS_WRITE: begin
                csr_we      = 1'b1;
                csr_waddr   = r_csr_addr;
                csr_wdata   = (r_op == OP_CSRRS) ? (r_old | r_rs1) : r_rs1;
                w_state_nxt = DONE;
            end
            DONE: begin
                resp_valid  = 1'b1;
                w_state_nxt = IDLE;
                if (r_op == OP_ECALL) begin
                    redirect_valid = 1'b1;
                    redirect_pc    = r_mtvec;
                end else if (r_op == OP_MRET) begin
                    redirect_valid = 1'b1;
                    redirect_pc    = r_mepc;
                end else if (r_op == OP_CSRRS || r_op == OP_CSRRW) begin
                    resp_result    = r_old;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_op       <= '0;
            r_csr_addr <= '0;
            r_pc       <= '0;
            r_rs1      <= '0;
            r_mtvec    <= '0;
            r_mepc     <= '0;
            r_old      <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_op       <= req_op;
                        r_csr_addr <= req_csr_addr;
                        r_pc       <= req_pc;
                        r_rs1      <= req_rs1;
                    end
                end
                EC_RTVEC:                     r_mtvec <= csr_rdata;
                MR_REPC:                      r_mepc  <= csr_rdata;
                EC_RSTAT, MR_RSTAT, CS_READ:  r_old   <= csr_rdata;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_22040895_trap_ctrl.sv
// Directed bench for the trap/CSR sequencer with a behavioural CSR file.
module tb_ysyx_22040895_trap_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_op = '0;
    logic [11:0] req_csr_addr = '0;
    logic [63:0] req_pc = '0;
    logic [63:0] req_rs1 = '0;
    logic [11:0] csr_raddr;
    logic [63:0] csr_rdata;
    logic        csr_we;
    logic [11:0] csr_waddr;
    logic [63:0] csr_wdata;
    logic        resp_valid;
    logic [63:0] resp_result;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;

    logic [63:0] csr_mem [0:4095];
    logic        pl_we = 1'b0;
    logic [11:0] pl_addr = '0;
    logic [63:0] pl_data = '0;
    int we_cnt = 0, resp_cnt = 0, redir_cnt = 0;

    ysyx_22040895_trap_ctrl dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_csr_addr(req_csr_addr), .req_pc(req_pc), .req_rs1(req_rs1),
        .csr_raddr(csr_raddr), .csr_rdata(csr_rdata), .csr_we(csr_we),
        .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
        .resp_valid(resp_valid), .resp_result(resp_result),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .busy(busy)
    );

    always #5 clk = ~clk;

    assign csr_rdata = csr_mem[csr_raddr];

    always @(posedge clk) begin
        if (csr_we) csr_mem[csr_waddr] <= csr_wdata;
        else if (pl_we) csr_mem[pl_addr] <= pl_data;
        if (csr_we) we_cnt <= we_cnt + 1;
        if (resp_valid) resp_cnt <= resp_cnt + 1;
        if (redirect_valid) redir_cnt <= redir_cnt + 1;
    end

    task automatic preload(input logic [11:0] a, input logic [63:0] d);
        @(negedge clk);
        pl_addr = a; pl_data = d; pl_we = 1'b1;
        @(negedge clk);
        pl_we = 1'b0;
    endtask

    // Issues one request, scrambles the req_* inputs after acceptance and
    // returns the number of edges until resp_valid together with the response.
    task automatic run_req(input logic [2:0] op, input logic [11:0] addr,
                           input logic [63:0] pc, input logic [63:0] rs1,
                           output int lat, output logic [63:0] res,
                           output logic rv, output logic [63:0] rpc);
        @(negedge clk);
        req_valid = 1'b1; req_op = op; req_csr_addr = addr; req_pc = pc; req_rs1 = rs1;
        @(posedge clk); #1;
        req_valid = 1'b0; req_op = ~op; req_csr_addr = ~addr; req_pc = ~pc; req_rs1 = ~rs1;
        lat = 1;
        while (!resp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        res = resp_result; rv = redirect_valid; rpc = redirect_pc;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b want 1", req_ready); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
        n_vec++; if ({csr_we, resp_valid, redirect_valid} !== 3'b000) begin n_err++; $display("FAIL reset_strobes got %b want 000", {csr_we, resp_valid, redirect_valid}); end
        n_vec++; if ({csr_raddr, csr_waddr, csr_wdata, resp_result, redirect_pc} !== '0) begin n_err++; $display("FAIL reset_data got nonzero raddr=%h waddr=%h wdata=%h res=%h rpc=%h want 0", csr_raddr, csr_waddr, csr_wdata, resp_result, redirect_pc); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_ecall;
        int lat; logic [63:0] res, rpc; logic rv; int w0;
        preload(12'h305, 64'h8000_0100);
        preload(12'h300, 64'h8);
        preload(12'h341, 64'h0);
        preload(12'h342, 64'h0);
        w0 = we_cnt;
        run_req(3'b001, 12'h0, 64'h8000_0040, 64'h0, lat, res, rv, rpc);
        n_vec++; if (lat !== 6) begin n_err++; $display("FAIL ecall_latency got %0d want 6", lat); end
        n_vec++; if (rv !== 1'b1 || rpc !== 64'h8000_0100) begin n_err++; $display("FAIL ecall_redirect got v=%b pc=%h want v=1 pc=8000_0100", rv, rpc); end
        n_vec++; if (res !== 64'h0) begin n_err++; $display("FAIL ecall_result got %h want 0", res); end
        n_vec++; if (csr_mem[12'h341] !== 64'h8000_0040) begin n_err++; $display("FAIL ecall_mepc got %h want 8000_0040", csr_mem[12'h341]); end
        n_vec++; if (csr_mem[12'h342] !== 64'd11) begin n_err++; $display("FAIL ecall_mcause got %h want b", csr_mem[12'h342]); end
        n_vec++; if (csr_mem[12'h300] !== 64'h1880) begin n_err++; $display("FAIL ecall_mstatus got %h want 1880", csr_mem[12'h300]); end
        n_vec++; if (we_cnt - w0 !== 3) begin n_err++; $display("FAIL ecall_writes got %0d want 3", we_cnt - w0); end
        n_vec++; if (busy !== 1'b0 || req_ready !== 1'b1) begin n_err++; $display("FAIL ecall_idle got busy=%b ready=%b want 0/1", busy, req_ready); end
    endtask

    task automatic test_mret;
        int lat; logic [63:0] res, rpc; logic rv;
        preload(12'h341, 64'h8000_0044);
        preload(12'h300, 64'h1880);
        run_req(3'b010, 12'h0, 64'h0, 64'h0, lat, res, rv, rpc);
        n_vec++; if (lat !== 4) begin n_err++; $display("FAIL mret_latency got %0d want 4", lat); end
        n_vec++; if (rv !== 1'b1 || rpc !== 64'h8000_0044) begin n_err++; $display("FAIL mret_redirect got v=%b pc=%h want v=1 pc=8000_0044", rv, rpc); end
        n_vec++; if (csr_mem[12'h300] !== 64'h88) begin n_err++; $display("FAIL mret_mstatus got %h want 88", csr_mem[12'h300]); end
        n_vec++; if (res !== 64'h0) begin n_err++; $display("FAIL mret_result got %h want 0", res); end
    endtask

    task automatic test_csrrs;
        int lat; logic [63:0] res, rpc; logic rv; int w0;
        preload(12'h300, 64'h8);
        run_req(3'b011, 12'h300, 64'h0, 64'h80, lat, res, rv, rpc);
        n_vec++; if (lat !== 3) begin n_err++; $display("FAIL csrrs_latency got %0d want 3", lat); end
        n_vec++; if (res !== 64'h8) begin n_err++; $display("FAIL csrrs_result got %h want 8", res); end
        n_vec++; if (csr_mem[12'h300] !== 64'h88) begin n_err++; $display("FAIL csrrs_mstatus got %h want 88", csr_mem[12'h300]); end
        n_vec++; if (rv !== 1'b0 || rpc !== 64'h0) begin n_err++; $display("FAIL csrrs_redirect got v=%b pc=%h want 0/0", rv, rpc); end
        w0 = we_cnt;
        run_req(3'b011, 12'h300, 64'h0, 64'h0, lat, res, rv, rpc);
        n_vec++; if (lat !== 2) begin n_err++; $display("FAIL csrrs0_latency got %0d want 2", lat); end
        n_vec++; if (we_cnt - w0 !== 0) begin n_err++; $display("FAIL csrrs0_writes got %0d want 0", we_cnt - w0); end
        n_vec++; if (res !== 64'h88) begin n_err++; $display("FAIL csrrs0_result got %h want 88", res); end
    endtask

    task automatic test_csrrw;
        int lat; logic [63:0] res, rpc; logic rv;
        preload(12'h305, 64'h1234);
        run_req(3'b100, 12'h305, 64'h0, 64'h8000_0000, lat, res, rv, rpc);
        n_vec++; if (lat !== 3) begin n_err++; $display("FAIL csrrw_latency got %0d want 3", lat); end
        n_vec++; if (res !== 64'h1234) begin n_err++; $display("FAIL csrrw_result got %h want 1234", res); end
        n_vec++; if (csr_mem[12'h305] !== 64'h8000_0000) begin n_err++; $display("FAIL csrrw_mtvec got %h want 8000_0000", csr_mem[12'h305]); end
        n_vec++; if (rv !== 1'b0) begin n_err++; $display("FAIL csrrw_redirect got %b want 0", rv); end
    endtask

    task automatic test_reset_abort;
        int w0, r0, d0;
        preload(12'h341, 64'h0);
        preload(12'h342, 64'h5);
        preload(12'h300, 64'h8);
        r0 = resp_cnt; d0 = redir_cnt;
        @(negedge clk);
        req_valid = 1'b1; req_op = 3'b001; req_csr_addr = '0; req_pc = 64'h8000_0040; req_rs1 = '0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_vec++; if (csr_we !== 1'b1 || csr_waddr !== 12'h342) begin n_err++; $display("FAIL abort_in_wcause got we=%b waddr=%h want 1/342", csr_we, csr_waddr); end
        rst = 1'b1;
        #1;
        w0 = we_cnt;
        n_vec++; if (busy !== 1'b0 || csr_we !== 1'b0) begin n_err++; $display("FAIL abort_immediate got busy=%b we=%b want 0/0", busy, csr_we); end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_vec++; if (we_cnt - w0 !== 0) begin n_err++; $display("FAIL abort_writes got %0d want 0", we_cnt - w0); end
        n_vec++; if (csr_mem[12'h341] !== 64'h8000_0040) begin n_err++; $display("FAIL abort_mepc got %h want 8000_0040", csr_mem[12'h341]); end
        n_vec++; if (csr_mem[12'h342] !== 64'h5) begin n_err++; $display("FAIL abort_mcause got %h want 5", csr_mem[12'h342]); end
        n_vec++; if (csr_mem[12'h300] !== 64'h8) begin n_err++; $display("FAIL abort_mstatus got %h want 8", csr_mem[12'h300]); end
        n_vec++; if (resp_cnt != r0 || redir_cnt != d0) begin n_err++; $display("FAIL abort_pulses got resp=%0d redir=%0d want 0/0", resp_cnt - r0, redir_cnt - d0); end
        n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL abort_ready got %b want 1", req_ready); end
    endtask

    task automatic test_back_to_back;
        int lat; int w0;
        preload(12'h305, 64'h5555);
        w0 = we_cnt;
        @(negedge clk);
        req_valid = 1'b1; req_op = 3'b101; req_csr_addr = 12'h300; req_pc = 64'h0; req_rs1 = 64'h1;
        @(posedge clk); #1;
        n_vec++; if (resp_valid !== 1'b1 || resp_result !== 64'h0 || redirect_valid !== 1'b0) begin n_err++; $display("FAIL b2b_first got v=%b res=%h rv=%b want 1/0/0", resp_valid, resp_result, redirect_valid); end
        n_vec++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL b2b_done_ready got %b want 0", req_ready); end
        req_op = 3'b100; req_csr_addr = 12'h305; req_rs1 = 64'hABCD;
        @(posedge clk); #1;
        n_vec++; if (busy !== 1'b0 || req_ready !== 1'b1 || resp_valid !== 1'b0) begin n_err++; $display("FAIL b2b_idle got busy=%b ready=%b resp=%b want 0/1/0", busy, req_ready, resp_valid); end
        @(posedge clk); #1;
        n_vec++; if (busy !== 1'b1 || csr_raddr !== 12'h305) begin n_err++; $display("FAIL b2b_accept got busy=%b raddr=%h want 1/305", busy, csr_raddr); end
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        n_vec++; if (lat !== 3 || resp_result !== 64'h5555) begin n_err++; $display("FAIL b2b_second got lat=%0d res=%h want 3/5555", lat, resp_result); end
        @(posedge clk); #1;
        n_vec++; if (csr_mem[12'h305] !== 64'hABCD || we_cnt - w0 !== 1) begin n_err++; $display("FAIL b2b_write got mtvec=%h writes=%0d want abcd/1", csr_mem[12'h305], we_cnt - w0); end
    endtask

    initial begin
        test_reset();
        test_ecall();
        test_mret();
        test_csrrs();
        test_csrrw();
        test_reset_abort();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ysyx_22040895_trap_ctrl.md
YSYX_22040895_TRAP_CTRL -- requirements
Module: ysyx_22040895_trap_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: clk input 1 (rising-edge clock); rst input 1 (asynchronous, active-high reset).
REQ-002 The request-side ports SHALL be:
  - req_valid input 1: request present.
  - req_ready output 1: block can accept a request.
  - req_op input 3: 001 ecall, 010 mret, 011 csrrs, 100 csrrw.
  - req_csr_addr input 12: CSR address for csrrs/csrrw.
  - req_pc input 64: PC of the requesting instruction.
  - req_rs1 input 64: rs1 operand value.
REQ-003 The CSR-file ports (single read/write port) SHALL be:
  - csr_raddr output 12: read address.
  - csr_rdata input 64: combinational read data for csr_raddr.
  - csr_we output 1: write strobe.
  - csr_waddr output 12: write address.
  - csr_wdata output 64: write data.
REQ-004 The response ports SHALL be:
  - resp_valid output 1: one-cycle completion pulse.
  - resp_result output 64: old CSR value for csrrs/csrrw, 0 otherwise.
  - redirect_valid output 1: one-cycle PC redirect pulse.
  - redirect_pc output 64: redirect target.
  - busy output 1: request in flight.

Function
REQ-005 A request SHALL be accepted on a rising edge where req_valid=1 and req_ready=1; req_ready=1 only in IDLE, and all req_* fields are captured at acceptance.
REQ-006 FSM states SHALL be IDLE, EC_RTVEC, EC_WEPC, EC_WCAUSE, EC_RSTAT, EC_WSTAT, MR_REPC, MR_RSTAT, MR_WSTAT, CS_READ, CS_WRITE, DONE; each non-IDLE, non-DONE state lasts exactly one cycle and performs at most one CSR-port access.
REQ-007 The ecall path SHALL be IDLE -> EC_RTVEC -> EC_WEPC -> EC_WCAUSE -> EC_RSTAT -> EC_WSTAT -> DONE, with the following accesses:
  - EC_RTVEC: read mtvec (0x305).
  - EC_WEPC: write mepc (0x341) = captured pc.
  - EC_WCAUSE: write mcause (0x342) = 11.
  - EC_RSTAT: read mstatus (0x300).
  - EC_WSTAT: write mstatus with MPIE(bit7)=old MIE(bit3), MIE=0, MPP(bits12:11)=2'b11, all other bits unchanged.
REQ-008 The mret path SHALL be IDLE -> MR_REPC (read mepc) -> MR_RSTAT (read mstatus) -> MR_WSTAT -> DONE; MR_WSTAT writes mstatus with MIE=old MPIE, MPIE=1, MPP=2'b00, all other bits unchanged.
REQ-009 The csrrs/csrrw path SHALL be IDLE -> CS_READ (read req_csr_addr, capture old value) -> CS_WRITE -> DONE, with the following rules:
  - csrrs writes old|rs1.
  - csrrw writes rs1.
  - csrrs with rs1==0 skips CS_WRITE and goes CS_READ -> DONE with no write.
REQ-010 Latency from the acceptance edge to DONE (measured in edges) SHALL be:
  - ecall: 6.
  - mret: 4.
  - csrrw, or csrrs with rs1!=0: 3.
  - csrrs with rs1==0: 2.
REQ-011 In DONE, resp_valid SHALL be 1 for exactly one cycle, then the FSM returns to IDLE; redirect_valid=1 in DONE for ecall (redirect_pc=captured mtvec) and for mret (redirect_pc=captured mepc); otherwise redirect_valid=0 and redirect_pc=0.
REQ-012 resp_result SHALL equal the captured old CSR value in DONE for csrrs/csrrw and 0 in all other cases.
REQ-013 An unsupported req_op (000, 101-111) SHALL go IDLE -> DONE with no CSR write, resp_result=0, and redirect_valid=0.
REQ-014 csr_we SHALL be 1 only in EC_WEPC, EC_WCAUSE, EC_WSTAT, MR_WSTAT and CS_WRITE; csr_raddr, csr_waddr and csr_wdata SHALL be 0 when not in use.
REQ-015 busy SHALL equal (state != IDLE), and req_ready SHALL equal !busy.
REQ-016 A req_valid held high during DONE SHALL NOT be accepted until the following IDLE cycle; back-to-back requests therefore have at least one IDLE cycle between them.
REQ-017 Captured 64-bit values SHALL be held unchanged for the whole sequence, independent of any req_* changes after acceptance.

Reset
REQ-018 While rst=1, the state SHALL be IDLE and all captured registers 0.
REQ-019 While rst=1, outputs SHALL be: req_ready=1, busy=0, csr_we=0, resp_valid=0, redirect_valid=0, and all data outputs 0.
REQ-020 Reset asserted mid-sequence SHALL abort immediately; no further CSR write occurs, and any partial writes already performed remain in the CSR file.

Structure
REQ-021 A shared package SHALL hold:
  - The op encodings (OP_ECALL=3'b001, OP_MRET=3'b010, OP_CSRRS=3'b011, OP_CSRRW=3'b100).
  - The CSR addresses (MSTATUS=12'h300, MTVEC=12'h305, MEPC=12'h341, MCAUSE=12'h342).
  - The mstatus bit indices (MIE=3, MPIE=7, MPP=12:11).
  - The ecall cause value 11.
  - The FSM state enum.
REQ-022 The mstatus rewrite functions for ecall and mret SHALL be placed in one sub-module, ysyx_22040895_mstatus_upd, which is combinational; the controller holds all state.

Verification
REQ-023 Ecall test: with mtvec=0x8000_0100, mstatus=0x8 (MIE=1), issue ecall with pc=0x8000_0040. Required response:
  - mepc=0x8000_0040.
  - mcause=11.
  - mstatus=0x1880.
  - redirect_pc=0x8000_0100 with redirect_valid on the 6th edge.
REQ-024 Mret test: with mepc=0x8000_0044, mstatus=0x1880, issue mret -> mstatus=0x88, redirect_pc=0x8000_0044, resp_valid on the 4th edge.
REQ-025 Csrrs test: with mstatus=0x8, issue csrrs at 0x300 with rs1=0x80 -> resp_result=0x8, mstatus=0x88; repeat with rs1=0 -> no csr_we pulse, resp_valid on the 2nd edge.
REQ-026 Csrrw test: with mtvec=0x1234, issue csrrw at 0x305 with rs1=0x8000_0000 -> resp_result=0x1234, mtvec=0x8000_0000, redirect_valid=0.
REQ-027 Reset-abort test: assert rst during EC_WCAUSE -> mepc already written, mcause unchanged, mstatus unchanged, resp_valid and redirect_valid never pulse, req_ready=1 after reset.
REQ-028 Back-to-back test: hold req_valid=1 with op=101 then csrrw -> first request completes on the 1st edge with resp_result=0, one IDLE cycle follows, and the csrrw is accepted next.
